mastermind_scorer: RTL and testbench
====================================

Name: mastermind_scorer

Overview:
Parametrised, multi-cycle Mastermind scoring engine and game tracker. It is the successor to the fixed 4-peg/3-bit compare and guess-counter logic. It scores one guess against a latched code with correct duplicate-colour handling, and counts guesses up to a limit. It also flags win/lose and sits between the control FSM and the HEX display decoders.

Parameters:
PEGS, 4, number of pegs per code/guess (>=2)
COLOR_W, 3, bits per peg colour
MAX_GUESSES, 8, guesses allowed per game (>=1)
(derived, not overridable: SCORE_W = $clog2(PEGS+1); GCNT_W = $clog2(MAX_GUESSES+1))

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
new_game  in  1  clear game state; abort any scoring in progress
start  in  1  request scoring of guess against code; sampled only when accepted
code  in  PEGS*COLOR_W  secret code; peg i = code[i*COLOR_W +: COLOR_W]
guess  in  PEGS*COLOR_W  current guess, same packing
busy  out  1  scoring in progress
done  out  1  one-cycle pulse: results updated this cycle
red  out  SCORE_W  exact (colour+position) matches of last scored guess
white  out  SCORE_W  colour-only matches of last scored guess
guess_count  out  GCNT_W  guesses scored this game
win  out  1  last scored guess had red == PEGS (sticky until new_game)
lose  out  1  MAX_GUESSES scored without win (sticky until new_game)
game_over  out  1  win | lose

Behaviour:
- Reset (resetn=0 at clk edge): state IDLE; busy, done, red, white, guess_count, win, lose all 0; internal used-flags cleared.
- Accept: start=1 in IDLE with game_over=0 and new_game=0. On accept, latch code and guess into internal regs, clear code_used[PEGS] and guess_used[PEGS], set index i=0, go to RED, and busy=1.
- start is ignored while busy or while game_over=1. Inputs are not re-sampled during scoring.
- RED (PEGS cycles, i=0..PEGS-1): if code[i]==guess[i], set code_used[i], set guess_used[i], and increment the internal red count. When i reaches PEGS-1, go to WHITE with i=0.
- WHITE (PEGS cycles, i=0..PEGS-1): if !code_used[i], find the lowest j with !guess_used[j] and guess[j]==code[i]. If found, set guess_used[j] and increment the internal white count. At most one white per code peg. When i reaches PEGS-1, go to FIN.
- FIN (1 cycle): copy red/white to outputs and increment guess_count. Set win if red==PEGS. Else set lose if guess_count+1==MAX_GUESSES. Assert done=1 for this cycle only, then return to IDLE with busy=0.
- Latency: done is high exactly 2*PEGS+1 cycles after the accept edge; for PEGS=4 that is 9 cycles.
- red/white outputs hold their previous values while busy. red+white <= PEGS always.
- new_game=1 (any state): next edge goes to IDLE. It clears red, white, guess_count, win, lose, busy, and the internal counts, with no done pulse. new_game has priority over start and over FIN in the same cycle.
- resetn has priority over new_game.
- Win on the final allowed guess: win=1, lose=0.
- guess_count saturates at MAX_GUESSES; further starts are blocked by game_over.

Test Plan:
- Reset, then PEGS=4, COLOR_W=3, code pegs {1,2,3,4}, guess {1,2,3,4}, start pulse -> done exactly 9 cycles later; red=4, white=0, win=1, game_over=1, guess_count=1; a further start gives no busy.
- Duplicates: code {1,1,2,2}, guess {1,2,1,0} -> red=1, white=2. Then code {5,5,5,5}, guess {5,0,0,0} -> red=1, white=0.
- No overlap: code {0,1,2,3}, guess {4,5,6,7}, repeated 8 times -> red=0 and white=0 each time; lose=1 after the 8th done, guess_count=8; 9th start ignored, no done.
- Abort: start, then new_game on cycle 3 of RED -> busy=0 next cycle, no done pulse, red/white/guess_count=0. start and new_game in the same cycle -> start ignored.
- Input stability: change guess on the cycle after accept -> result reflects the latched guess only.
- Parameter variant PEGS=6, COLOR_W=3, MAX_GUESSES=10: code {1,2,3,4,5,6}, guess {6,5,4,3,2,1} -> red=0, white=6, done 13 cycles after accept.

Source files
------------

// File: rtl/mastermind_scorer.sv
// Multi-cycle Mastermind scorer: exact matches in PEGS cycles, then colour-only matches in PEGS cycles, then publish.
// Tracks guesses per game and raises sticky win/lose flags.
module mastermind_scorer #(
  parameter  int PEGS        = 4,
  parameter  int COLOR_W     = 3,
  parameter  int MAX_GUESSES = 8,
  localparam int SCORE_W     = $clog2(PEGS + 1),
  localparam int GCNT_W      = $clog2(MAX_GUESSES + 1)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    new_game,
  input  logic                    start,
  input  logic [PEGS*COLOR_W-1:0] code,
  input  logic [PEGS*COLOR_W-1:0] guess,
  output logic                    busy,
  output logic                    done,
  output logic [SCORE_W-1:0]      red,
  output logic [SCORE_W-1:0]      white,
  output logic [GCNT_W-1:0]       guess_count,
  output logic                    win,
  output logic                    lose,
  output logic                    game_over
);

  localparam int IDX_W = $clog2(PEGS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PEGS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RED, S_WHITE, S_FIN} state_t;
  typedef logic [PEGS-1:0][COLOR_W-1:0] pegs_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  pegs_t               code_q, code_d;
  pegs_t               guess_q, guess_d;
  logic [PEGS-1:0]     code_used_q, code_used_d;
  logic [PEGS-1:0]     guess_used_q, guess_used_d;
  logic [SCORE_W-1:0]  red_cnt_q, red_cnt_d;
  logic [SCORE_W-1:0]  white_cnt_q, white_cnt_d;
  logic [SCORE_W-1:0]  red_q, red_d;
  logic [SCORE_W-1:0]  white_q, white_d;
  logic [GCNT_W-1:0]   gcnt_q, gcnt_d;
  logic                win_q, win_d;
  logic                lose_q, lose_d;
  logic                done_q, done_d;

  // Lowest unused guess peg whose colour matches the current code peg.
  logic                wfound;
  logic [PEGS-1:0]     wmask;

  always_comb begin
    wfound = 1'b0;
    wmask  = '0;
    for (int j = 0; j < PEGS; j++) begin
      if (!wfound && !guess_used_q[j] && guess_q[j] == code_q[idx_q]) begin
        wfound   = 1'b1;
        wmask[j] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    code_d       = code_q;
    guess_d      = guess_q;
    code_used_d  = code_used_q;
    guess_used_d = guess_used_q;
    red_cnt_d    = red_cnt_q;
    white_cnt_d  = white_cnt_q;
    red_d        = red_q;
    white_d      = white_q;
    gcnt_d       = gcnt_q;
    win_d        = win_q;
    lose_d       = lose_q;
    done_d       = 1'b0;

    if (new_game) begin
      state_d      = S_IDLE;
      idx_d        = '0;
      code_used_d  = '0;
      guess_used_d = '0;
      red_cnt_d    = '0;
      white_cnt_d  = '0;
      red_d        = '0;
      white_d      = '0;
      gcnt_d       = '0;
      win_d        = 1'b0;
      lose_d       = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !(win_q || lose_q)) begin
            code_d       = code;
            guess_d      = guess;
            code_used_d  = '0;
            guess_used_d = '0;
            red_cnt_d    = '0;
            white_cnt_d  = '0;
            idx_d        = '0;
            state_d      = S_RED;
          end
        end
        S_RED: begin
          if (code_q[idx_q] == guess_q[idx_q]) begin
            code_used_d[idx_q]  = 1'b1;
            guess_used_d[idx_q] = 1'b1;
            red_cnt_d           = red_cnt_q + SCORE_W'(1);
          end
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = S_WHITE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        S_WHITE: begin
          if (!code_used_q[idx_q] && wfound) begin
            guess_used_d = guess_used_q | wmask;
            white_cnt_d  = white_cnt_q + SCORE_W'(1);
          end
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = S_FIN;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        S_FIN: begin
          red_d   = red_cnt_q;
          white_d = white_cnt_q;
          if (gcnt_q != GCNT_W'(MAX_GUESSES)) begin
            gcnt_d = gcnt_q + GCNT_W'(1);
          end
          if (red_cnt_q == SCORE_W'(PEGS)) begin
            win_d = 1'b1;
          end else if (gcnt_q + GCNT_W'(1) == GCNT_W'(MAX_GUESSES)) begin
            lose_d = 1'b1;
          end
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      code_q       <= '0;
      guess_q      <= '0;
      code_used_q  <= '0;
      guess_used_q <= '0;
      red_cnt_q    <= '0;
      white_cnt_q  <= '0;
      red_q        <= '0;
      white_q      <= '0;
      gcnt_q       <= '0;
      win_q        <= 1'b0;
      lose_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      code_q       <= code_d;
      guess_q      <= guess_d;
      code_used_q  <= code_used_d;
      guess_used_q <= guess_used_d;
      red_cnt_q    <= red_cnt_d;
      white_cnt_q  <= white_cnt_d;
      red_q        <= red_d;
      white_q      <= white_d;
      gcnt_q       <= gcnt_d;
      win_q        <= win_d;
      lose_q       <= lose_d;
      done_q       <= done_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign red         = red_q;
  assign white       = white_q;
  assign guess_count = gcnt_q;
  assign win         = win_q;
  assign lose        = lose_q;
  assign game_over   = win_q | lose_q;

endmodule

// File: tb/tb_mastermind_scorer.sv
// Bench for mastermind_scorer: directed scenarios plus random games on a 4-peg instance, one directed run on a 6-peg instance.
module tb_mastermind_scorer;

  logic        clk = 1'b0;
  logic        resetn;

  logic        new_game4, start4;
  logic [11:0] code4, guess4;
  logic        busy4, done4, win4, lose4, go4;
  logic [2:0]  red4, white4;
  logic [3:0]  gcnt4;

  logic        new_game6, start6;
  logic [17:0] code6, guess6;
  logic        busy6, done6, win6, lose6, go6;
  logic [2:0]  red6, white6;
  logic [3:0]  gcnt6;

  int total = 0;
  int bad   = 0;

  int e_gcnt, e_red, e_white;
  bit e_win, e_lose;

  always #5 clk = ~clk;

  mastermind_scorer u_dut4 (
    .clk(clk), .resetn(resetn), .new_game(new_game4), .start(start4),
    .code(code4), .guess(guess4), .busy(busy4), .done(done4),
    .red(red4), .white(white4), .guess_count(gcnt4),
    .win(win4), .lose(lose4), .game_over(go4)
  );

  mastermind_scorer #(.PEGS(6), .COLOR_W(3), .MAX_GUESSES(10)) u_dut6 (
    .clk(clk), .resetn(resetn), .new_game(new_game6), .start(start6),
    .code(code6), .guess(guess6), .busy(busy6), .done(done6),
    .red(red6), .white(white6), .guess_count(gcnt6),
    .win(win6), .lose(lose6), .game_over(go6)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Exact hits by position; total colour hits from per-colour minimum counts.
  function automatic void model(input logic [47:0] c, input logic [47:0] g, input int n,
                                output int r, output int w);
    int cc[8];
    int gc[8];
    for (int k = 0; k < 8; k++) begin
      cc[k] = 0;
      gc[k] = 0;
    end
    r = 0;
    w = 0;
    for (int i = 0; i < n; i++) begin
      if (c[i*3 +: 3] == g[i*3 +: 3]) r++;
      cc[c[i*3 +: 3]]++;
      gc[g[i*3 +: 3]]++;
    end
    for (int k = 0; k < 8; k++) w += (cc[k] < gc[k]) ? cc[k] : gc[k];
    w -= r;
  endfunction

  task automatic model_clear();
    e_gcnt = 0; e_red = 0; e_white = 0; e_win = 0; e_lose = 0;
  endtask

  task automatic pulse_new_game4();
    @(negedge clk); new_game4 = 1'b1;
    @(negedge clk); new_game4 = 1'b0;
    model_clear();
    chk("ng_busy", busy4, 0);
    chk("ng_gcnt", gcnt4, 0);
    chk("ng_red", red4, 0);
    chk("ng_over", go4, 0);
  endtask

  // Score one guess; code/guess inputs are scrambled after accept to prove latching.
  task automatic run4(input logic [11:0] c, input logic [11:0] g, input logic [11:0] g_late);
    int r, w, cyc;
    model({36'd0, c}, {36'd0, g}, 4, r, w);
    @(negedge clk); code4 = c; guess4 = g; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0; guess4 = g_late; code4 = ~c;
    chk("busy_after_accept", busy4, 1);
    chk("hold_red", red4, e_red);
    chk("hold_white", white4, e_white);
    cyc = 0;
    while (!done4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("latency4", cyc, 9);
    e_gcnt++;
    e_red = r;
    e_white = w;
    e_win = (r == 4);
    e_lose = !e_win && (e_gcnt == 8);
    chk("red4", red4, e_red);
    chk("white4", white4, e_white);
    chk("gcnt4", gcnt4, e_gcnt);
    chk("win4", win4, e_win);
    chk("lose4", lose4, e_lose);
    chk("over4", go4, e_win | e_lose);
    chk("busy_at_done", busy4, 0);
    @(negedge clk);
    chk("done_one_cycle", done4, 0);
  endtask

  task automatic no_done_window4(input string tag);
    int dn = 0;
    repeat (14) begin
      @(negedge clk);
      if (done4) dn++;
    end
    chk(tag, dn, 0);
    chk("window_busy", busy4, 0);
  endtask

  task automatic blocked_start4();
    @(negedge clk); start4 = 1'b1; code4 = 12'h000; guess4 = 12'h000;
    @(negedge clk); start4 = 1'b0;
    chk("blocked_busy", busy4, 0);
    no_done_window4("blocked_no_done");
    chk("blocked_gcnt", gcnt4, e_gcnt);
  endtask

  initial begin
    int cyc, r, w, dn;
    logic [11:0] rc, rg;
    resetn = 1'b0;
    new_game4 = 0; start4 = 0; code4 = '0; guess4 = '0;
    new_game6 = 0; start6 = 0; code6 = '0; guess6 = '0;
    model_clear();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy4, 0);
    chk("rst_done", done4, 0);
    chk("rst_red", red4, 0);
    chk("rst_white", white4, 0);
    chk("rst_gcnt", gcnt4, 0);
    chk("rst_win", win4, 0);
    chk("rst_lose", lose4, 0);
    chk("rst_busy6", busy6, 0);

    // Immediate win, then further starts are ignored.
    run4({3'd4, 3'd3, 3'd2, 3'd1}, {3'd4, 3'd3, 3'd2, 3'd1}, 12'h000);
    blocked_start4();

    // Duplicate-colour handling.
    pulse_new_game4();
    run4({3'd2, 3'd2, 3'd1, 3'd1}, {3'd0, 3'd1, 3'd2, 3'd1}, 12'hfff);
    chk("dup_white_2", white4, 2);
    run4({3'd5, 3'd5, 3'd5, 3'd5}, {3'd0, 3'd0, 3'd0, 3'd5}, 12'h555);
    chk("dup_white_0", white4, 0);

    // Eight misses lose the game; ninth start is ignored.
    pulse_new_game4();
    for (int k = 0; k < 8; k++) begin
      run4({3'd3, 3'd2, 3'd1, 3'd0}, {3'd7, 3'd6, 3'd5, 3'd4}, 12'h123);
    end
    chk("lose_final", lose4, 1);
    chk("lose_gcnt", gcnt4, 8);
    blocked_start4();

    // Abort on RED cycle 3.
    pulse_new_game4();
    run4({3'd4, 3'd3, 3'd2, 3'd1}, {3'd0, 3'd0, 3'd2, 3'd1}, 12'h000);
    @(negedge clk); start4 = 1'b1; code4 = 12'h111; guess4 = 12'h111;
    @(negedge clk); start4 = 1'b0;
    @(negedge clk);
    @(negedge clk); new_game4 = 1'b1;
    @(negedge clk); new_game4 = 1'b0;
    model_clear();
    chk("abort_busy", busy4, 0);
    chk("abort_done", done4, 0);
    chk("abort_red", red4, 0);
    chk("abort_white", white4, 0);
    chk("abort_gcnt", gcnt4, 0);
    no_done_window4("abort_no_done");

    // start together with new_game is dropped.
    @(negedge clk); start4 = 1'b1; new_game4 = 1'b1;
    @(negedge clk); start4 = 1'b0; new_game4 = 1'b0;
    chk("ng_start_busy", busy4, 0);
    no_done_window4("ng_start_no_done");
    chk("ng_start_gcnt", gcnt4, 0);

    // Input stability: guess changes right after accept.
    run4({3'd1, 3'd6, 3'd2, 3'd0}, {3'd6, 3'd1, 3'd2, 3'd7}, {3'd1, 3'd6, 3'd2, 3'd0});

    // Random games over a small palette so matches and duplicates are common.
    for (int gm = 0; gm < 5; gm++) begin
      pulse_new_game4();
      for (int p = 0; p < 4; p++) rc[p*3 +: 3] = 3'($urandom_range(0, 3));
      while (!e_win && !e_lose) begin
        for (int p = 0; p < 4; p++) rg[p*3 +: 3] = 3'($urandom_range(0, 3));
        if ($urandom_range(0, 5) == 0) rg = rc;
        run4(rc, rg, 12'($urandom));
      end
      blocked_start4();
    end

    // Six-peg instance: full permutation reversal.
    model({30'd0, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1},
          {30'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6}, 6, r, w);
    @(negedge clk);
    code6  = {3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
    guess6 = {3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    start6 = 1'b1;
    @(negedge clk); start6 = 1'b0; guess6 = '0;
    chk("busy6", busy6, 1);
    cyc = 0;
    while (!done6 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    chk("latency6", cyc, 13);
    chk("red6", red6, r);
    chk("white6", white6, w);
    chk("gcnt6", gcnt6, 1);
    chk("win6", win6, 0);
    chk("lose6", lose6, 0);
    dn = 0;
    @(negedge clk);
    if (done6) dn++;
    chk("done6_one_cycle", dn, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
